// File: rtl/fruit_spawner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spawner_pkg
//  Description : Shared types and field widths for the fruit spawner:
//                FSM state encoding, spawn record layout and the helper
//                that turns a speed magnitude into a centre-seeking vx.
//  Revision    : 1.0  initial release
// ============================================================================
package spawner_pkg;

    localparam int X_W     = 11;   // spawn x width
    localparam int VX_W    = 4;    // signed horizontal velocity width
    localparam int VY_W    = 5;    // unsigned launch speed width
    localparam int TYPE_W  = 2;    // fruit type width
    localparam int GAP_W   = 7;    // frame gap counter width (max 93)
    localparam int VY_BASE = 16;   // minimum launch speed

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_DRAW0 = 3'd2,
        S_DRAW1 = 3'd3,
        S_OFFER = 3'd4
    } spawner_state_t;

    typedef struct packed {
        logic [X_W-1:0]    x;
        logic [VX_W-1:0]   vx;
        logic [VY_W-1:0]   vy;
        logic [TYPE_W-1:0] ftype;
        logic              bomb;
    } spawn_rec_t;

    // Fruit launched from the right half drifts left (negative vx) and
    // vice versa, so every fruit heads toward the middle of the screen.
    function automatic logic [VX_W-1:0] drift_vx(input logic [2:0] mag,
                                                 input logic       right_half);
        logic [VX_W-1:0] m;
        m = {1'b0, mag};
        return right_half ? (~m + 1'b1) : m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fruit_spawner_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module      : spawn_gap_timer
//  Description : Frame gap counter between spawns. Loads a gap value,
//                counts down one per frame tick while enabled and flags
//                zero. Never underflows: it sits at zero until reloaded.
//  Ports       : clk_in, rst_in       clock, async active-high reset
//                load, load_val       load a new gap (has priority)
//                dec_en               counting window (spawner in WAIT)
//                frame_tick_in        one-cycle frame pulse
//                zero                 counter is zero
//  Revision    : 1.0  initial release
// ============================================================================
import spawner_pkg::*;

module spawn_gap_timer (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    input  logic             dec_en,
    input  logic             frame_tick_in,
    output logic             zero
);

    logic [GAP_W-1:0] count;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec_en && frame_tick_in && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/fruit_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : fruit_spawner
//  Description : Turns the free-running LFSR word into randomized fruit
//                spawn requests. Waits MIN_GAP + rand[5:0] frames, draws
//                x/vx/vy from one LFSR word and type from the next, then
//                offers the record on a valid/ready handshake. Caps the
//                number of live fruit at MAX_ACTIVE.
//  Options     : SPAWN_BOMB_EN - when defined, a record is flagged as a
//                bomb when rand_in[7:4] == 0 in the type-draw cycle;
//                otherwise spawn_bomb_out is constant 0.
//  Ports       : clk_in, rst_in           clock, async active-high reset
//                enable_in                game running; low parks spawner
//                frame_tick_in            one pulse per video frame
//                rand_in[15:0]            LFSR word, advances every cycle
//                spawn_valid_out/ready_in record handshake
//                spawn_x_out[10:0]        spawn x
//                spawn_vx_out[3:0]        signed horizontal velocity
//                spawn_vy_out[4:0]        launch speed
//                spawn_type_out[1:0]      fruit type
//                spawn_bomb_out           bomb flag
//                fruit_done_in            one fruit retired (pulse)
//                active_count_out[2:0]    live fruit count
//  Revision    : 1.0  initial release
// ============================================================================
import spawner_pkg::*;

module fruit_spawner #(
    parameter int MIN_GAP    = 30,
    parameter int X_MIN      = 64,
    parameter int MAX_ACTIVE = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              enable_in,
    input  logic              frame_tick_in,
    input  logic [15:0]       rand_in,
    output logic              spawn_valid_out,
    input  logic              spawn_ready_in,
    output logic [X_W-1:0]    spawn_x_out,
    output logic [VX_W-1:0]   spawn_vx_out,
    output logic [VY_W-1:0]   spawn_vy_out,
    output logic [TYPE_W-1:0] spawn_type_out,
    output logic              spawn_bomb_out,
    input  logic              fruit_done_in,
    output logic [2:0]        active_count_out
);

    spawner_state_t   state;
    spawner_state_t   state_nxt;
    logic             gap_load;
    logic             gap_zero;
    logic [GAP_W-1:0] gap_load_val;
    logic             draw0;
    logic             draw1;
    logic             accept;
    logic             can_spawn;
    logic [X_W-1:0]   x_draw;
    logic             right_half;
    spawn_rec_t       rec;
    logic [2:0]       active_count;
    logic             unused_rand;

    // Bit 15 of the LFSR word is not used by any draw.
    assign unused_rand = rand_in[15];

    assign gap_load_val = GAP_W'(MIN_GAP) + GAP_W'(rand_in[5:0]);
    assign accept       = (state == S_OFFER) && spawn_ready_in;
    assign can_spawn    = (active_count < 3'(MAX_ACTIVE));

    spawn_gap_timer u_gap_timer (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .load          (gap_load),
        .load_val      (gap_load_val),
        .dec_en        (state == S_WAIT),
        .frame_tick_in (frame_tick_in),
        .zero          (gap_zero)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gap_load  = 1'b0;
        draw0     = 1'b0;
        draw1     = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable_in) begin
                    gap_load  = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // At the fruit cap the timer simply sits at zero here.
                if (!enable_in) begin
                    state_nxt = S_IDLE;
                end else if (gap_zero && can_spawn) begin
                    state_nxt = S_DRAW0;
                end
            end
            S_DRAW0: begin
                if (!enable_in) begin
                    state_nxt = S_IDLE;
                end else begin
                    draw0     = 1'b1;
                    state_nxt = S_DRAW1;
                end
            end
            S_DRAW1: begin
                if (!enable_in) begin
                    state_nxt = S_IDLE;
                end else begin
                    draw1     = 1'b1;
                    state_nxt = S_OFFER;
                end
            end
            S_OFFER: begin
                // An offered record is never dropped, even when disabled.
                if (spawn_ready_in) begin
                    if (enable_in) begin
                        gap_load  = 1'b1;
                        state_nxt = S_WAIT;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Record draw. Position and velocities come from one LFSR word; the
    // type comes from the following word so it is independent of x.
    // ------------------------------------------------------------------
    assign x_draw     = X_W'(X_MIN) + X_W'(rand_in[8:0]);
    assign right_half = (x_draw >= X_W'(X_MIN + 256));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rec <= '0;
        end else begin
            if (draw0) begin
                rec.x  <= x_draw;
                rec.vx <= drift_vx(rand_in[11:9], right_half);
                rec.vy <= VY_W'(VY_BASE) + VY_W'(rand_in[14:12]);
            end
            if (draw1) begin
                rec.ftype <= rand_in[1:0];
`ifdef SPAWN_BOMB_EN
                rec.bomb  <= (rand_in[7:4] == 4'h0);
`else
                rec.bomb  <= 1'b0;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Live fruit counter; accept and retire in the same cycle cancel.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            active_count <= '0;
        end else begin
            case ({accept, fruit_done_in})
                2'b10:   active_count <= active_count + 1'b1;
                2'b01:   if (active_count != '0) active_count <= active_count - 1'b1;
                default: active_count <= active_count;
            endcase
        end
    end

    assign spawn_valid_out  = (state == S_OFFER);
    assign spawn_x_out      = rec.x;
    assign spawn_vx_out     = rec.vx;
    assign spawn_vy_out     = rec.vy;
    assign spawn_type_out   = rec.ftype;
    assign spawn_bomb_out   = rec.bomb;
    assign active_count_out = active_count;

endmodule
`default_nettype wire

// File: tb/tb_fruit_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fruit_spawner
//  Description : Directed self-checking bench for fruit_spawner. Inputs are
//                driven and outputs sampled on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fruit_spawner;

`ifdef SPAWN_BOMB_EN
    localparam logic BOMB_ON = 1'b1;
`else
    localparam logic BOMB_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        enable;
    logic        frame_tick;
    logic [15:0] rand_w;
    logic        valid;
    logic        ready;
    logic [10:0] sx;
    logic [3:0]  svx;
    logic [4:0]  svy;
    logic [1:0]  stype;
    logic        sbomb;
    logic        done;
    logic [2:0]  count;

    int n_assert = 0;
    int n_fail   = 0;

    fruit_spawner dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .enable_in        (enable),
        .frame_tick_in    (frame_tick),
        .rand_in          (rand_w),
        .spawn_valid_out  (valid),
        .spawn_ready_in   (ready),
        .spawn_x_out      (sx),
        .spawn_vx_out     (svx),
        .spawn_vy_out     (svy),
        .spawn_type_out   (stype),
        .spawn_bomb_out   (sbomb),
        .fruit_done_in    (done),
        .active_count_out (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // n consecutive frame ticks; returns on the falling edge after the last.
    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) @(negedge clk);
        frame_tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; frame_tick = 1'b0;
        rand_w = 16'h0000; ready = 1'b0; done = 1'b0;
        cyc(2);
        check("reset_valid", 32'(valid), 0);
        check("reset_count", 32'(count), 0);
        check("reset_x",     32'(sx),    0);
        check("reset_bomb",  32'(sbomb), 0);
        rst = 1'b0;
        cyc(5);
        check("idle_no_valid", 32'(valid), 0);

        // rand = 0: gap 30, record x=64 vx=0 vy=16 type=0
        ready = 1'b1; enable = 1'b1;
        cyc(1);
        ticks(29); cyc(4);
        check("gap30_early", 32'(valid), 0);
        ticks(1);
        check("lat0", 32'(valid), 0);
        cyc(1); check("lat1", 32'(valid), 0);
        cyc(1); check("lat2", 32'(valid), 0);
        cyc(1); check("lat3", 32'(valid), 1);
        check("r0_x",    32'(sx),    64);
        check("r0_vx",   32'(svx),   0);
        check("r0_vy",   32'(svy),   16);
        check("r0_type", 32'(stype), 0);
        check("r0_bomb", 32'(sbomb), 32'(BOMB_ON));
        rand_w = 16'hFFFF;              // gap reload at acceptance -> 93
        cyc(1);
        check("acc1_valid", 32'(valid), 0);
        check("acc1_count", 32'(count), 1);
        ready = 1'b0;

        // rand = FFFF: gap 93, record x=575 vx=-7 vy=23 type=3
        ticks(92); cyc(4);
        check("gap93_early", 32'(valid), 0);
        ticks(1); cyc(3);
        check("r1_valid", 32'(valid), 1);
        check("r1_x",    32'(sx),    575);
        check("r1_vx",   32'(svx),   9);
        check("r1_vy",   32'(svy),   23);
        check("r1_type", 32'(stype), 3);
        check("r1_bomb", 32'(sbomb), 0);

        // stall: fields hold while rand_in churns
        for (int i = 0; i < 10; i++) begin
            rand_w = 16'($urandom);
            cyc(1);
            check("stall_valid", 32'(valid), 1);
            check("stall_x",     32'(sx),    575);
            check("stall_vy",    32'(svy),   23);
        end
        rand_w = 16'h0000;
        ready = 1'b1;
        cyc(1);
        check("acc2_valid", 32'(valid), 0);
        check("acc2_count", 32'(count), 2);

        // fill to the cap
        for (int i = 0; i < 2; i++) begin
            ticks(30); cyc(3);
            check("fill_valid", 32'(valid), 1);
            cyc(1);
        end
        check("cap_count", 32'(count), 4);
        ticks(30); cyc(10);
        check("cap_no_valid", 32'(valid), 0);
        check("cap_count_hold", 32'(count), 4);

        // one fruit retires -> spawn resumes 3 cycles later
        done = 1'b1; cyc(1); done = 1'b0;
        check("done_count", 32'(count), 3);
        cyc(2); check("done_lat2", 32'(valid), 0);
        cyc(1); check("done_lat3", 32'(valid), 1);
        done = 1'b1; cyc(1); done = 1'b0;
        check("coinc_count", 32'(count), 3);
        check("coinc_valid", 32'(valid), 0);

        // enable drop in WAIT abandons the spawn
        ticks(30);
        enable = 1'b0;
        cyc(6);
        check("abandon_valid", 32'(valid), 0);

        // second LFSR word drives type/bomb; enable drop during OFFER holds record
        rand_w = 16'h0000; enable = 1'b1; ready = 1'b0;
        cyc(1);
        ticks(30);
        cyc(1);
        cyc(1); rand_w = 16'h0003;
        cyc(1);
        check("d1_valid", 32'(valid), 1);
        check("d1_type",  32'(stype), 3);
        check("d1_x",     32'(sx),    64);
        check("d1_bomb",  32'(sbomb), 32'(BOMB_ON));
        enable = 1'b0;
        cyc(3);
        check("off_hold_valid", 32'(valid), 1);
        check("off_hold_type",  32'(stype), 3);
        ready = 1'b1; cyc(1); ready = 1'b0;
        check("off_acc_valid", 32'(valid), 0);
        check("off_acc_count", 32'(count), 4);
        ticks(30); cyc(5);
        check("parked_valid", 32'(valid), 0);

        // reset while a record is offered
        done = 1'b1; cyc(1); done = 1'b0;
        rand_w = 16'h0000; enable = 1'b1;
        cyc(1);
        ticks(30); cyc(3);
        check("pre_rst_valid", 32'(valid), 1);
        rst = 1'b1; enable = 1'b0;
        #1;
        check("rst_valid", 32'(valid), 0);
        check("rst_count", 32'(count), 0);
        cyc(1); rst = 1'b0;
        cyc(5);
        check("post_rst_valid", 32'(valid), 0);
        check("post_rst_count", 32'(count), 0);
        check("post_rst_x",     32'(sx),    0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fruit_spawner.md
Name: fruit_spawner

Overview:
Consumes the free-running 16-bit LFSR word and turns it into randomized fruit spawn requests for the downstream fruit physics/object table. It waits a randomized number of frames between spawns, then draws position, velocity and type from the LFSR. The result is offered on a valid/ready handshake. It also caps the number of simultaneously active fruit.

Parameters:
MIN_GAP, 30, minimum frames between spawns; actual gap = MIN_GAP + rand[5:0] (30..93).
X_MIN, 64, leftmost spawn x; spawn x range is X_MIN..X_MIN+511.
MAX_ACTIVE, 4, maximum live fruit; no spawn is offered while active_count_out == MAX_ACTIVE.

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-high
enable_in  input  1  game running; low parks the spawner
frame_tick_in  input  1  one-cycle pulse per video frame
rand_in  input  16  LFSR q_out; must advance every clk_in cycle
spawn_valid_out  output  1  spawn record valid
spawn_ready_in  input  1  downstream accepts record
spawn_x_out  output  11  spawn x position, unsigned
spawn_vx_out  output  4  horizontal velocity, signed two's complement
spawn_vy_out  output  5  upward launch speed, unsigned
spawn_type_out  output  2  fruit type 0..3
spawn_bomb_out  output  1  record is a bomb (see Optional Feature)
fruit_done_in  input  1  one-cycle pulse: one active fruit left screen or was sliced
active_count_out  output  3  live fruit count

Behaviour:
- Reset (async assert, sync to clk_in edge on release):
  - state = IDLE; gap counter = 0; active_count_out = 0.
  - spawn_valid_out = 0; all spawn fields = 0; spawn_bomb_out = 0.
- States: IDLE, WAIT, DRAW0, DRAW1, OFFER.
- IDLE: when enable_in = 1, load gap = MIN_GAP + rand_in[5:0] and go to WAIT.
- WAIT:
  - Gap counter decrements by 1 on each frame_tick_in.
  - When the counter is 0 and active_count_out < MAX_ACTIVE, go to DRAW0 on the next edge.
  - At MAX_ACTIVE, hold in WAIT with the counter at 0 (no underflow).
- DRAW0 (1 cycle), latching from rand_in:
  - x = X_MIN + rand_in[8:0].
  - mag = rand_in[11:9].
  - vx = -mag if x >= X_MIN+256, else +mag (fruit drifts toward centre).
  - vy = 16 + rand_in[14:12] (range 16..23).
- DRAW1 (1 cycle): latch type = rand_in[1:0] from the next LFSR word, so it is decorrelated from x.
- OFFER:
  - spawn_valid_out = 1; all fields stable until accepted.
  - On valid & ready: active_count_out increments, gap reloads from the current rand_in, go to WAIT.
  - spawn_valid_out drops the cycle after acceptance.
- Latency: spawn_valid_out rises on the 3rd clk_in edge after the edge at which the gap counter reaches 0.
- enable_in falling:
  - In WAIT/DRAW0/DRAW1: go to IDLE next edge and abandon the draw.
  - In OFFER: the record is never dropped; hold until accepted, then go to IDLE.
  - active_count_out is retained across IDLE.
- fruit_done_in decrements active_count_out, saturating at 0.
  - Simultaneous accept and done: count unchanged.
- frame_tick_in outside WAIT is ignored.

Optional Feature:
Macro SPAWN_BOMB_EN.
- Defined: in DRAW1, if rand_in[7:4] == 4'h0 (1/16 probability), spawn_bomb_out = 1 for that record.
  - spawn_type_out is still drawn normally.
  - Bombs count toward active_count_out.
- Undefined: spawn_bomb_out is tied to 0; no extra logic.

Decomposition:
- Package spawner_pkg:
  - state enum spawner_state_t.
  - localparams for field widths (X_W=11, VX_W=4, VY_W=5, TYPE_W=2).
  - VY_BASE=16.
  - packed struct spawn_rec_t {x, vx, vy, type, bomb}.
- One natural sub-module, spawn_gap_timer:
  - Loads the gap, decrements on frame_tick_in, flags zero.
- Active counter and FSM live in the top.

Test Plan:
- Reset mid-OFFER (valid high) -> next cycle valid=0, active_count=0, state IDLE; no spurious record after release with enable=0.
- enable=1, rand_in held 16'h0000, ready=1 -> valid after exactly 30 ticks (+3 cycles); record x=64, vx=0, vy=16, type=0.
- rand_in held 16'hFFFF -> gap 93 ticks; record x=575, vx=-7 (4'b1001), vy=23, type=3.
- ready=0 for 10 cycles during OFFER, with rand_in changing -> fields stable and valid held; accepted on first ready cycle; count 0->1.
- ready=1, no fruit_done, 4 spawns -> count=4 and no 5th valid despite counter=0; one fruit_done pulse -> count 3, valid 3 cycles later; done coincident with acceptance -> count unchanged.
- SPAWN_BOMB_EN defined, DRAW1 word 16'h0003 -> bomb=1, type=3; undefined -> bomb=0.
